// File: rtl/morse_key_classifier.sv
// Morse key front end: synchronises and debounces the raw key, times presses and
// gaps, and hands out dot / dash / char break / word break symbols over valid/ready.
module morse_key_classifier #(
    parameter int unsigned CNT_W           = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned MIN_PRESS       = 15000000,
    parameter int unsigned DASH_THRESH     = 39000000,
    parameter int unsigned CHAR_GAP        = 15000000,
    parameter int unsigned WORD_GAP        = 91000000
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       key_n,
    output logic       key_down,
    output logic       sym_valid,
    output logic [1:0] sym_code,
    input  logic       sym_ready,
    output logic       overflow
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PRESS = 2'b01,
        ST_GAP   = 2'b10
    } state_t;

    localparam logic [1:0] SYM_DOT  = 2'b00;
    localparam logic [1:0] SYM_DASH = 2'b01;
    localparam logic [1:0] SYM_CHAR = 2'b10;
    localparam logic [1:0] SYM_WORD = 2'b11;

    localparam logic [CNT_W-1:0] DB_LAST      = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CHAR_GAP_L   = CNT_W'(CHAR_GAP);
    localparam logic [CNT_W-1:0] WORD_GAP_L   = CNT_W'(WORD_GAP);
    localparam logic [CNT_W:0]   MIN_PRESS_L  = (CNT_W + 1)'(MIN_PRESS);
    localparam logic [CNT_W:0]   DASH_THRESH_L = (CNT_W + 1)'(DASH_THRESH);
    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONES     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    logic             sync1_r;
    logic             sync2_r;
    logic             key_lvl_s;
    logic [CNT_W-1:0] db_cnt_r;
    logic             key_down_r;
    logic             key_prev_r;
    logic             edge_s;
    logic [CNT_W-1:0] dur_r;
    logic [CNT_W:0]   press_len_s;

    state_t           state_r;
    state_t           state_n;
    logic             from_gap_r;
    logic             from_gap_n;
    logic             char_done_r;
    logic             char_done_n;
    logic             ev_valid_s;
    logic [1:0]       ev_code_s;

    logic             sym_valid_r;
    logic [1:0]       sym_code_r;
    logic             overflow_r;

    // Two-flop synchroniser; idles at the released level.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= key_n;
            sync2_r <= sync1_r;
        end
    end

    assign key_lvl_s = ~sync2_r;

    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            db_cnt_r   <= CNT_ZERO;
            key_down_r <= 1'b0;
        end else if (key_lvl_s != key_down_r) begin
            if (db_cnt_r == DB_LAST) begin
                key_down_r <= ~key_down_r;
                db_cnt_r   <= CNT_ZERO;
            end else begin
                db_cnt_r <= db_cnt_r + CNT_ONE;
            end
        end else begin
            db_cnt_r <= CNT_ZERO;
        end
    end

    // Previous debounced level, used to see key_down edges.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            key_prev_r <= 1'b0;
        end else begin
            key_prev_r <= key_down_r;
        end
    end

    assign edge_s = key_down_r ^ key_prev_r;

    // Shared press/gap duration counter, saturating at all-ones.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            dur_r <= CNT_ZERO;
        end else if (edge_s) begin
            dur_r <= CNT_ZERO;
        end else if (dur_r != CNT_ONES) begin
            dur_r <= dur_r + CNT_ONE;
        end
    end

    // The counter is cleared one cycle into the press, so add that cycle back.
    assign press_len_s = {1'b0, dur_r} + {{CNT_W{1'b0}}, 1'b1};

    // FSM state register.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            from_gap_r  <= 1'b0;
            char_done_r <= 1'b0;
        end else begin
            state_r     <= state_n;
            from_gap_r  <= from_gap_n;
            char_done_r <= char_done_n;
        end
    end

    // FSM next state and symbol event generation.
    always_comb begin
        state_n     = state_r;
        from_gap_n  = from_gap_r;
        char_done_n = char_done_r;
        ev_valid_s  = 1'b0;
        ev_code_s   = SYM_DOT;
        case (state_r)
            ST_IDLE: begin
                if (key_down_r) begin
                    state_n    = ST_PRESS;
                    from_gap_n = 1'b0;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_PRESS: begin
                if (!key_down_r) begin
                    if (press_len_s < MIN_PRESS_L) begin
                        state_n = from_gap_r ? ST_GAP : ST_IDLE;
                    end else begin
                        ev_valid_s  = 1'b1;
                        ev_code_s   = (press_len_s >= DASH_THRESH_L) ? SYM_DASH : SYM_DOT;
                        state_n     = ST_GAP;
                        char_done_n = 1'b0;
                    end
                end else begin
                    state_n = ST_PRESS;
                end
            end
            ST_GAP: begin
                if (key_down_r) begin
                    state_n    = ST_PRESS;
                    from_gap_n = 1'b1;
                end else if (char_done_r && (dur_r >= WORD_GAP_L)) begin
                    ev_valid_s = 1'b1;
                    ev_code_s  = SYM_WORD;
                    state_n    = ST_IDLE;
                end else if (!char_done_r && (dur_r >= CHAR_GAP_L)) begin
                    ev_valid_s  = 1'b1;
                    ev_code_s   = SYM_CHAR;
                    char_done_n = 1'b1;
                end else begin
                    state_n = ST_GAP;
                end
            end
            default: begin
                state_n     = ST_IDLE;
                from_gap_n  = 1'b0;
                char_done_n = 1'b0;
            end
        endcase
    end

    // One-entry output register with back-to-back loading and sticky drop flag.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sym_valid_r <= 1'b0;
            sym_code_r  <= SYM_DOT;
            overflow_r  <= 1'b0;
        end else if (ev_valid_s) begin
            if (!sym_valid_r || sym_ready) begin
                sym_valid_r <= 1'b1;
                sym_code_r  <= ev_code_s;
            end else begin
                overflow_r <= 1'b1;
            end
        end else if (sym_valid_r && sym_ready) begin
            sym_valid_r <= 1'b0;
        end
    end

    assign key_down  = key_down_r;
    assign sym_valid = sym_valid_r;
    assign sym_code  = sym_code_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_morse_key_classifier.sv
// Directed bench for morse_key_classifier with short timing parameters.
module tb_morse_key_classifier;

    logic       CLOCK_50;
    logic       reset_n;
    logic       key_n;
    logic       key_down;
    logic       sym_valid;
    logic [1:0] sym_code;
    logic       sym_ready;
    logic       overflow;

    int         n_cmp;
    int         n_fail;
    int         cyc;
    logic [1:0] ev_q [$];
    int         ev_t [$];

    morse_key_classifier #(
        .CNT_W(32),
        .DEBOUNCE_CYCLES(4),
        .MIN_PRESS(10),
        .DASH_THRESH(30),
        .CHAR_GAP(20),
        .WORD_GAP(60)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset_n(reset_n),
        .key_n(key_n),
        .key_down(key_down),
        .sym_valid(sym_valid),
        .sym_code(sym_code),
        .sym_ready(sym_ready),
        .overflow(overflow)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Record every accepted symbol just after the falling edge, before the next rising edge.
    always @(negedge CLOCK_50) begin
        #2;
        if (reset_n === 1'b1 && sym_valid === 1'b1 && sym_ready === 1'b1) begin
            ev_q.push_back(sym_code);
            ev_t.push_back(cyc);
        end
    end

    task automatic do_reset();
        reset_n   = 1'b0;
        key_n     = 1'b1;
        sym_ready = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        reset_n = 1'b1;
        ev_q.delete();
        ev_t.delete();
        @(negedge CLOCK_50);
    endtask

    task automatic press(input int n);
        key_n = 1'b0;
        repeat (n) @(negedge CLOCK_50);
        key_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (key_down !== 1'b0) begin n_fail++; $display("FAIL reset_key_down: got %b want 0", key_down); end
        n_cmp++; if (sym_valid !== 1'b0) begin n_fail++; $display("FAIL reset_sym_valid: got %b want 0", sym_valid); end
        n_cmp++; if (sym_code !== 2'b00) begin n_fail++; $display("FAIL reset_sym_code: got %b want 00", sym_code); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_glitch();
        logic [1:0] exp_ev [5] = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b11};
        do_reset();
        press(3);
        repeat (20) @(negedge CLOCK_50);
        n_cmp++; if (key_down !== 1'b0) begin n_fail++; $display("FAIL glitch_key_down: got %b want 0", key_down); end
        n_cmp++; if (ev_q.size() !== 0) begin n_fail++; $display("FAIL glitch_no_event: got %0d events want 0", ev_q.size()); end
        key_n = 1'b0;
        repeat (5) @(negedge CLOCK_50);
        n_cmp++; if (key_down !== 1'b0) begin n_fail++; $display("FAIL debounce_early: got %b want 0 at cycle 5", key_down); end
        @(negedge CLOCK_50);
        n_cmp++; if (key_down !== 1'b1) begin n_fail++; $display("FAIL debounce_latency: got %b want 1 at cycle 6", key_down); end
        repeat (14) @(negedge CLOCK_50);
        key_n = 1'b1;
        repeat (30) @(negedge CLOCK_50);
        press(35);
        repeat (100) @(negedge CLOCK_50);
        n_cmp++; if (ev_q.size() !== 5) begin n_fail++; $display("FAIL glitch_ev_count: got %0d want 5", ev_q.size()); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (i >= ev_q.size()) begin
                n_fail++; $display("FAIL glitch_ev%0d: got none want %b", i, exp_ev[i]);
            end else if (ev_q[i] !== exp_ev[i]) begin
                n_fail++; $display("FAIL glitch_ev%0d: got %b want %b", i, ev_q[i], exp_ev[i]);
            end
        end
    endtask

    task automatic test_short_press();
        logic [1:0] exp_ev [3] = '{2'b00, 2'b10, 2'b11};
        do_reset();
        press(6);
        repeat (100) @(negedge CLOCK_50);
        n_cmp++; if (ev_q.size() !== 0) begin n_fail++; $display("FAIL short_no_event: got %0d events want 0", ev_q.size()); end
        press(15);
        repeat (100) @(negedge CLOCK_50);
        n_cmp++; if (ev_q.size() !== 3) begin n_fail++; $display("FAIL short_ev_count: got %0d want 3", ev_q.size()); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (i >= ev_q.size()) begin
                n_fail++; $display("FAIL short_ev%0d: got none want %b", i, exp_ev[i]);
            end else if (ev_q[i] !== exp_ev[i]) begin
                n_fail++; $display("FAIL short_ev%0d: got %b want %b", i, ev_q[i], exp_ev[i]);
            end
        end
    endtask

    task automatic test_gap_ladder();
        logic [1:0] exp_ev [8] = '{2'b00, 2'b10, 2'b11, 2'b00, 2'b10, 2'b00, 2'b10, 2'b11};
        do_reset();
        press(20);
        repeat (100) @(negedge CLOCK_50);
        n_cmp++; if (ev_q.size() !== 3) begin n_fail++; $display("FAIL ladder_count: got %0d want 3", ev_q.size()); end
        if (ev_t.size() >= 3) begin
            n_cmp++; if (ev_t[1] - ev_t[0] !== 21) begin n_fail++; $display("FAIL ladder_char_time: got %0d want 21", ev_t[1] - ev_t[0]); end
            n_cmp++; if (ev_t[2] - ev_t[0] !== 61) begin n_fail++; $display("FAIL ladder_word_time: got %0d want 61", ev_t[2] - ev_t[0]); end
        end
        repeat (50) @(negedge CLOCK_50);
        n_cmp++; if (ev_q.size() !== 3) begin n_fail++; $display("FAIL ladder_quiet: got %0d want 3", ev_q.size()); end
        press(20);
        repeat (25) @(negedge CLOCK_50);
        press(20);
        repeat (100) @(negedge CLOCK_50);
        n_cmp++; if (ev_q.size() !== 8) begin n_fail++; $display("FAIL ladder_total: got %0d want 8", ev_q.size()); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (i >= ev_q.size()) begin
                n_fail++; $display("FAIL ladder_ev%0d: got none want %b", i, exp_ev[i]);
            end else if (ev_q[i] !== exp_ev[i]) begin
                n_fail++; $display("FAIL ladder_ev%0d: got %b want %b", i, ev_q[i], exp_ev[i]);
            end
        end
    endtask

    task automatic test_leading_gap();
        do_reset();
        repeat (200) @(negedge CLOCK_50);
        n_cmp++; if (ev_q.size() !== 0) begin n_fail++; $display("FAIL lead_no_event: got %0d events want 0", ev_q.size()); end
        n_cmp++; if (sym_valid !== 1'b0) begin n_fail++; $display("FAIL lead_sym_valid: got %b want 0", sym_valid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        sym_ready = 1'b0;
        press(20);
        repeat (40) @(negedge CLOCK_50);
        n_cmp++; if (sym_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held: got %b want 1", sym_valid); end
        n_cmp++; if (sym_code !== 2'b00) begin n_fail++; $display("FAIL bp_code_held: got %b want 00", sym_code); end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_overflow: got %b want 1", overflow); end
        sym_ready = 1'b1;
        @(negedge CLOCK_50);
        n_cmp++; if (sym_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop: got %b want 0", sym_valid); end
        n_cmp++; if (ev_q.size() !== 1) begin n_fail++; $display("FAIL bp_transfers: got %0d want 1", ev_q.size()); end
        if (ev_q.size() >= 1) begin
            n_cmp++; if (ev_q[0] !== 2'b00) begin n_fail++; $display("FAIL bp_code: got %b want 00", ev_q[0]); end
        end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_reset_mid_press();
        do_reset();
        key_n = 1'b0;
        repeat (25) @(negedge CLOCK_50);
        n_cmp++; if (key_down !== 1'b1) begin n_fail++; $display("FAIL mid_key_down_pre: got %b want 1", key_down); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (key_down !== 1'b0) begin n_fail++; $display("FAIL mid_key_down: got %b want 0", key_down); end
        n_cmp++; if (sym_valid !== 1'b0) begin n_fail++; $display("FAIL mid_sym_valid: got %b want 0", sym_valid); end
        n_cmp++; if (sym_code !== 2'b00) begin n_fail++; $display("FAIL mid_sym_code: got %b want 00", sym_code); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mid_overflow: got %b want 0", overflow); end
        key_n = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        reset_n = 1'b1;
        repeat (150) @(negedge CLOCK_50);
        n_cmp++; if (ev_q.size() !== 0) begin n_fail++; $display("FAIL mid_no_event: got %0d events want 0", ev_q.size()); end
        n_cmp++; if (key_down !== 1'b0) begin n_fail++; $display("FAIL mid_key_down_post: got %b want 0", key_down); end
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        cyc       = 0;
        reset_n   = 1'b0;
        key_n     = 1'b1;
        sym_ready = 1'b1;
        test_reset();
        test_glitch();
        test_short_press();
        test_gap_ladder();
        test_leading_gap();
        test_backpressure();
        test_reset_mid_press();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
